// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send, then shifts one
// command byte out on device clock falls and checks the device acknowledge bit.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES  = 5000,
    parameter int unsigned REQ_HOLD_CYCLES = 50,
    parameter int unsigned TIMEOUT_CYCLES  = 100000,
    parameter int unsigned FILTER_LEN      = 8
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] cmd_byte,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err
);

    localparam int unsigned CntW  = $clog2(INHIBIT_CYCLES + REQ_HOLD_CYCLES + 1);
    localparam int unsigned WdW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StReq,
        StSend,
        StAck,
        StWaitIdle,
        StFin
    } state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WdW-1:0]   wd_q, wd_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [9:0]       shift_q, shift_d;
    logic             dat_oe_q, dat_oe_d;
    logic             nak_q, nak_d;
    logic             ack_err_q, ack_err_d;

    logic             clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
    logic             clk_filt_q;
    logic [FiltW-1:0] filt_cnt_q;
    logic             filt_flip, clk_fall, timeout;

    // Idle bus level is high, so the synchronizers and filter reset to 1.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= ps2_clk_in;
            clk_sync_q <= clk_meta_q;
            dat_meta_q <= ps2_dat_in;
            dat_sync_q <= dat_meta_q;
        end
    end

    assign filt_flip = (clk_sync_q != clk_filt_q) && (filt_cnt_q == FiltW'(FILTER_LEN - 1));
    assign clk_fall  = filt_flip && clk_filt_q;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            clk_filt_q <= 1'b1;
            filt_cnt_q <= '0;
        end else if (clk_sync_q == clk_filt_q) begin
            filt_cnt_q <= '0;
        end else if (filt_flip) begin
            clk_filt_q <= clk_sync_q;
            filt_cnt_q <= '0;
        end else begin
            filt_cnt_q <= filt_cnt_q + FiltW'(1);
        end
    end

    assign timeout = (wd_q == WdW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wd_d      = '0;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        dat_oe_d  = dat_oe_q;
        nak_d     = nak_q;
        ack_err_d = ack_err_q;

        unique case (state_q)
            StIdle, StFin: begin
                dat_oe_d = 1'b0;
                if (start) begin
                    shift_d   = {1'b1, ~^cmd_byte, cmd_byte};
                    ack_err_d = 1'b0;
                    nak_d     = 1'b0;
                    cnt_d     = '0;
                    state_d   = StInhibit;
                end else begin
                    state_d = StIdle;
                end
            end
            StInhibit: begin
                if (cnt_q == CntW'(INHIBIT_CYCLES - 1)) begin
                    cnt_d    = '0;
                    dat_oe_d = 1'b1;
                    state_d  = StReq;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StReq: begin
                if (cnt_q == CntW'(REQ_HOLD_CYCLES - 1)) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = StSend;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StSend: begin
                wd_d = wd_q + WdW'(1);
                if (timeout) begin
                    wd_d      = '0;
                    dat_oe_d  = 1'b0;
                    ack_err_d = 1'b1;
                    state_d   = StFin;
                end else if (clk_fall) begin
                    wd_d      = '0;
                    dat_oe_d  = ~shift_q[bit_cnt_q];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = StAck;
                    end
                end
            end
            StAck: begin
                wd_d = wd_q + WdW'(1);
                if (timeout) begin
                    wd_d      = '0;
                    dat_oe_d  = 1'b0;
                    ack_err_d = 1'b1;
                    state_d   = StFin;
                end else if (clk_fall) begin
                    wd_d    = '0;
                    nak_d   = dat_sync_q;
                    state_d = StWaitIdle;
                end
            end
            StWaitIdle: begin
                wd_d = wd_q + WdW'(1);
                if (timeout) begin
                    wd_d      = '0;
                    dat_oe_d  = 1'b0;
                    ack_err_d = 1'b1;
                    state_d   = StFin;
                end else if (clk_filt_q && dat_sync_q) begin
                    wd_d      = '0;
                    ack_err_d = nak_q;
                    state_d   = StFin;
                end
            end
            default: begin
                dat_oe_d = 1'b0;
                state_d  = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            wd_q      <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            dat_oe_q  <= 1'b0;
            nak_q     <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wd_q      <= wd_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            dat_oe_q  <= dat_oe_d;
            nak_q     <= nak_d;
            ack_err_q <= ack_err_d;
        end
    end

    // Clock enable decodes straight from state so an async reset frees the bus at once.
    assign ps2_clk_oe = (state_q == StInhibit) || (state_q == StReq);
    assign ps2_dat_oe = dat_oe_q;
    assign busy       = (state_q != StIdle) && (state_q != StFin);
    assign done       = (state_q == StFin);
    assign ack_err    = ack_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host while a per-cycle
// monitor compares the host's outputs with a transfer-age model.
module tb_ps2_host_tx;

    localparam int unsigned INH  = 20;
    localparam int unsigned REQ  = 4;
    localparam int unsigned TMO  = 2000;
    localparam int unsigned FLT  = 4;
    localparam int unsigned HALF = 20;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] cmd_byte;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_oe, ps2_dat_oe, busy, done, ack_err;
    logic       dev_clk_low, dev_dat_low;

    int         checks, errors;
    int         m_age, done_age, done_count, clk_oe_run, last_clk_oe_run, n0;
    logic       m_ack, m_exp_err, prev_dat_oe;
    logic [10:0] got;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .REQ_HOLD_CYCLES(REQ),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_LEN     (FLT)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .start     (start),
        .cmd_byte  (cmd_byte),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .busy      (busy),
        .done      (done),
        .ack_err   (ack_err)
    );

    // Open-drain wired-AND of host and device pull-downs.
    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame as the device sees it: start, 8 data LSB first, odd parity, stop.
    function automatic logic [10:0] frame_of(input logic [7:0] c);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(c[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, c, 1'b0};
    endfunction

    always @(negedge CLOCK_50) begin
        if (!reset) begin
            check("rst_clk_oe", ps2_clk_oe, 0);
            check("rst_dat_oe", ps2_dat_oe, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_ack_err", ack_err, 0);
            m_age = 0;
            m_ack = 1'b0;
            clk_oe_run = 0;
            prev_dat_oe = 1'b0;
        end else begin
            if (m_age == 0) begin
                check("idle_clk_oe", ps2_clk_oe, 0);
                check("idle_dat_oe", ps2_dat_oe, 0);
                check("idle_busy", busy, 0);
                check("idle_done", done, 0);
                check("idle_ack_err", ack_err, m_ack);
            end else if (done) begin
                check("done_busy", busy, 0);
                check("done_clk_oe", ps2_clk_oe, 0);
                check("done_dat_oe", ps2_dat_oe, 0);
                check("done_not_early", m_age > int'(INH + REQ), 1);
                check("done_ack_err", ack_err, m_exp_err);
                m_ack = m_exp_err;
                done_age = m_age;
                done_count++;
            end else begin
                check("xfer_busy", busy, 1);
                check("xfer_ack_err", ack_err, 0);
                check("xfer_clk_oe", ps2_clk_oe, m_age <= int'(INH + REQ));
                if (m_age <= int'(INH + REQ)) begin
                    check("req_dat_oe", ps2_dat_oe, m_age > int'(INH));
                end else if (m_age > int'(INH + REQ + 1) && ps2_dat_oe !== prev_dat_oe) begin
                    check("dat_change_clk_low", ps2_clk_in, 0);
                end
            end
            if (ps2_clk_oe) begin
                clk_oe_run++;
            end else if (clk_oe_run != 0) begin
                last_clk_oe_run = clk_oe_run;
                clk_oe_run = 0;
            end
            prev_dat_oe = ps2_dat_oe;
            if ((m_age == 0 || done) && start) m_age = 1;
            else if (done) m_age = 0;
            else if (m_age != 0) m_age++;
        end
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic do_start(input logic [7:0] c, input logic exp_err);
        cmd_byte = c;
        start = 1'b1;
        m_exp_err = exp_err;
        tick();
        start = 1'b0;
        cmd_byte = 8'h00;
    endtask

    task automatic wait_request(output bit ok);
        bit seen;
        ok = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!ps2_clk_in) seen = 1'b1;
            else if (seen && !ps2_dat_in) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("request_seen", ok, 1);
    endtask

    // One device clock: low half (sample host data at the end), then high half.
    task automatic dev_bit(input bit ack, input bit glitch, output logic b);
        dev_clk_low = 1'b1;
        dev_dat_low = ack;
        repeat (HALF) tick();
        b = ps2_dat_in;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        if (glitch) begin
            repeat (8) tick();
            dev_clk_low = 1'b1;
            repeat (2) tick();
            dev_clk_low = 1'b0;
            repeat (HALF - 10) tick();
        end else begin
            repeat (HALF) tick();
        end
    endtask

    task automatic run_frame(input bit ack, input bit glitch, output logic [10:0] f);
        bit ok;
        logic b;
        f = '0;
        wait_request(ok);
        if (ok) begin
            repeat (5) tick();
            f[0] = ps2_dat_in;
            for (int i = 1; i <= 11; i++) begin
                dev_bit(ack && i == 11, glitch && i == 3, b);
                if (i <= 10) f[i] = b;
            end
        end
    endtask

    task automatic wait_done(input int base, input int limit, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (done_count > base) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (done_count > base) seen = 1'b1;
        check(name, seen, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [7:0]  cmds[2];
        logic [10:0] lits[2];
        cmds = '{8'h00, 8'h01};
        lits = '{11'h600, 11'h402};
        checks = 0;
        errors = 0;
        done_count = 0;
        done_age = 0;
        last_clk_oe_run = 0;
        clk_oe_run = 0;
        m_age = 0;
        m_ack = 1'b0;
        m_exp_err = 1'b0;
        prev_dat_oe = 1'b0;
        start = 1'b0;
        cmd_byte = 8'h00;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) tick();
        check("reset_busy", busy, 0);
        check("reset_clk_oe", ps2_clk_oe, 0);
        reset = 1'b1;
        repeat (3) tick();

        // 0xED with acknowledge
        n0 = done_count;
        do_start(8'hED, 1'b0);
        run_frame(1'b1, 1'b0, got);
        check("frame_ED_model", got, frame_of(8'hED));
        check("frame_ED_literal", got, 11'h7DA);
        wait_done(n0, 200, "done_ED");
        check("clk_oe_hold_cycles", last_clk_oe_run, 24);
        repeat (5) tick();

        // Parity boundaries
        for (int k = 0; k < 2; k++) begin
            n0 = done_count;
            do_start(cmds[k], 1'b0);
            run_frame(1'b1, 1'b0, got);
            check("frame_par_model", got, frame_of(cmds[k]));
            check("frame_par_literal", got, lits[k]);
            wait_done(n0, 200, "done_par");
            repeat (5) tick();
        end

        // Missing acknowledge, then ack_err held and cleared by the next start
        n0 = done_count;
        do_start(8'hA5, 1'b1);
        run_frame(1'b0, 1'b0, got);
        check("frame_A5_model", got, frame_of(8'hA5));
        wait_done(n0, 200, "done_nak");
        repeat (30) tick();
        check("ack_err_held", ack_err, 1);
        n0 = done_count;
        do_start(8'h3C, 1'b0);
        check("ack_err_cleared", ack_err, 0);
        run_frame(1'b1, 1'b0, got);
        check("frame_3C_model", got, frame_of(8'h3C));
        wait_done(n0, 200, "done_3C");
        repeat (5) tick();

        // Device never clocks
        n0 = done_count;
        do_start(8'h12, 1'b1);
        wait_done(n0, 2200, "done_timeout");
        check("timeout_done_age", done_age, 2025);
        repeat (5) tick();

        // Start ignored while busy, plus a short clock glitch
        n0 = done_count;
        do_start(8'hED, 1'b0);
        fork
            run_frame(1'b1, 1'b1, got);
            begin
                repeat (130) tick();
                cmd_byte = 8'h55;
                start = 1'b1;
                tick();
                start = 1'b0;
                cmd_byte = 8'h00;
            end
        join
        check("frame_ignored_start", got, 11'h7DA);
        wait_done(n0, 200, "done_glitch");
        repeat (5) tick();

        // Reset in the middle of SEND
        begin
            bit ok;
            logic b;
            do_start(8'h77, 1'b0);
            wait_request(ok);
            repeat (5) tick();
            for (int i = 0; i < 3; i++) dev_bit(1'b0, 1'b0, b);
            dev_clk_low = 1'b1;
            repeat (10) tick();
            check("pre_reset_dat_oe", ps2_dat_oe, 1);
            check("pre_reset_busy", busy, 1);
            reset = 1'b0;
            #1;
            check("midrst_clk_oe", ps2_clk_oe, 0);
            check("midrst_dat_oe", ps2_dat_oe, 0);
            check("midrst_busy", busy, 0);
            dev_clk_low = 1'b0;
            dev_dat_low = 1'b0;
            repeat (3) tick();
            reset = 1'b1;
            repeat (3) tick();
        end
        n0 = done_count;
        do_start(8'hFF, 1'b0);
        run_frame(1'b1, 1'b0, got);
        check("frame_FF_model", got, frame_of(8'hFF));
        check("frame_FF_literal", got, 11'h7FE);
        wait_done(n0, 200, "done_FF");
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte (for example keyboard LED set 0xED, or reset 0xFF) to the keyboard on the shared PS2_CLK/PS2_DAT lines.
- It is the transmit side of the same interface whose receive side is the keyboard press driver.
- Both lines are open-drain. The block outputs only pull-low enables; the top level builds the tristates and feeds the pad values back in.

Parameters:
- INHIBIT_CYCLES, 5000: CLOCK_50 cycles that PS2_CLK is held low for the request (100 µs).
- REQ_HOLD_CYCLES, 50: cycles with both lines held low before PS2_CLK is released.
- TIMEOUT_CYCLES, 100000: per-edge watchdog (2 ms), counted while waiting for each device clock edge.
- FILTER_LEN, 8: number of consecutive equal synchronized PS2_CLK samples needed to accept a new level.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request. Accepted only when busy=0.
- cmd_byte  in  8  byte to send. Sampled on the accepted start cycle.
- ps2_clk_in  in  1  PS2_CLK pad value.
- ps2_dat_in  in  1  PS2_DAT pad value.
- ps2_clk_oe  out  1  1 = drive PS2_CLK low.
- ps2_dat_oe  out  1  1 = drive PS2_DAT low.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at the end of every transfer, good or failed.
- ack_err  out  1  valid with done and held until the next accepted start. 1 = device ack missing or timeout.

Behaviour:
- Reset (asserted low, asynchronous):
  - state IDLE; all counters 0.
  - ps2_clk_oe=0, ps2_dat_oe=0, busy=0, done=0, ack_err=0.
  - Reset asserted mid-transfer releases both lines immediately.
- Input conditioning:
  - ps2_clk_in and ps2_dat_in pass through a 2-FF synchronizer.
  - The clock is then filtered: the filtered level changes only after FILTER_LEN identical consecutive samples.
  - fall = 1-cycle strobe when the filtered clock goes 1->0.
- Shift register: 10 bits = {stop=1, parity, cmd_byte[7:0]}, sent LSB first. parity = ~^cmd_byte (odd parity).
- States:
  - IDLE: busy=0. On start: latch the shift register, clear ack_err, busy=1 on the next cycle, go to INHIBIT.
  - INHIBIT: clk_oe=1, dat_oe=0 for INHIBIT_CYCLES, then go to REQ.
  - REQ: clk_oe=1, dat_oe=1 (start bit 0) for REQ_HOLD_CYCLES, then clk_oe=0 and go to SEND with bit_cnt=0.
  - SEND: on each fall, dat_oe = ~shift[bit_cnt], then bit_cnt++. After the 10th fall (stop bit, dat_oe=0) go to ACK.
  - ACK: on the next fall, sample synchronized data. 0 = ack OK; 1 = ack_err=1. Go to WAIT_IDLE.
  - WAIT_IDLE: wait until filtered clk=1 and synchronized data=1, then go to FIN.
  - FIN: done=1 for one cycle, busy=0, go to IDLE.
- Watchdog:
  - Counts in SEND, ACK and WAIT_IDLE; cleared on each fall and on each state entry.
  - When it reaches TIMEOUT_CYCLES: release both lines, ack_err=1, go to FIN.
- start while busy=1 is ignored; there is no queueing.
- dat_oe changes only in the cycle after fall. It never changes while the filtered clock is high.
- A glitch shorter than FILTER_LEN cycles on the clock produces no fall and does not advance bit_cnt.
- Total latency for a good transfer: INHIBIT_CYCLES + REQ_HOLD_CYCLES + 11 device clocks + idle wait + 1.

Test Plan (bench overrides INHIBIT_CYCLES=20, REQ_HOLD_CYCLES=4, TIMEOUT_CYCLES=2000, FILTER_LEN=4; bench models the device at a 40-cycle clock period):
- Reset low mid-SEND -> within 1 cycle clk_oe=0, dat_oe=0, busy=0. After release, start with 0xFF completes normally.
- start with cmd 0xED, device acks -> clk_oe held low exactly 24 cycles (20+4); device samples 1,0,1,1,0,1,1,1, parity 1, stop 1; done pulse with ack_err=0.
- cmd 0x00 -> parity bit 1 and all data bits 0. cmd 0x01 -> parity bit 0.
- Device leaves data high at ack -> done with ack_err=1. ack_err stays 1 until the next start, then clears.
- Device never clocks after the request -> after 2000 cycles lines are released, done=1, ack_err=1, busy falls the same cycle.
- start pulsed again during SEND with 0x55 -> ignored; the transmitted byte is still 0xED. A 2-cycle low glitch on PS2_CLK -> no extra bit shifted.
